// File: rtl/cpu_pkg.sv
// cpu_pkg
// Definitions shared by the ALU and the Z writeback stage:
//   - the 5-bit ALU opcode constants
//   - the writeback FSM state enumeration
//   - is_wide_op(): true for operations that produce a 64-bit result
//     (Multiply and Division), which are written back as LO then HI
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_XFER_LO = 3'd3,
        S_XFER_HI = 3'd4,
        S_DONE    = 3'd5
    } zwb_state_t;

    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/zwb_settle_counter.sv
// zwb_settle_counter
// 4-bit loadable down-counter used to time the ALU settle delay.
// Ports:
//   clock      in   system clock
//   clear      in   asynchronous active-low reset (count -> 0)
//   load       in   load load_value this cycle (has priority over dec)
//   load_value in 4 value to load
//   dec        in   decrement request; the count saturates at 0
//   zero       out  count is 0
module zwb_settle_counter (
    input  logic       clock,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/z_writeback.sv
// z_writeback
// Captures the ALU's 64-bit Z result into the LO/HI architectural registers
// after an opcode-dependent settle delay, then writes it back over the shared
// 32-bit bus under a request/grant handshake: LO always, HI as well for
// Multiply/Division. One operation at a time; `done` pulses at the end.
// Ports:
//   clock      in      system clock
//   clear      in      asynchronous active-low reset
//   start      in      one-cycle operation strobe (only honoured in IDLE)
//   opcode     in  5   ALU opcode, latched with start
//   z_in       in  64  ALU Z output
//   bus_gnt    in      bus grant
//   busy       out     operation in progress
//   bus_req    out     bus requested (a word is pending)
//   bus_out    out 32  word on the bus, 0 unless bus_drive
//   bus_drive  out     a word transfers this cycle
//   lo, hi     out 32  LO / HI registers
//   done       out     one-cycle completion pulse
module z_writeback
    import cpu_pkg::*;
#(
    parameter int MUL_WAIT = 4,
    parameter int DIV_WAIT = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [63:0] z_in,
    input  logic        bus_gnt,
    output logic        busy,
    output logic        bus_req,
    output logic [31:0] bus_out,
    output logic        bus_drive,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        done
);

    // The counter is loaded with WAIT-1 so that SETTLE lasts exactly WAIT cycles.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_WAIT - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_WAIT - 1);

    zwb_state_t  state_reg;
    logic [4:0]  opcode_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;

    logic        settle_load;
    logic [3:0]  settle_value;
    logic        settle_dec;
    logic        settle_zero;
    logic        in_xfer;

    assign settle_load  = (state_reg == S_IDLE) && start;
    assign settle_value = (opcode == OP_MUL) ? MUL_LOAD :
                          (opcode == OP_DIV) ? DIV_LOAD : 4'd0;
    assign settle_dec   = (state_reg == S_SETTLE);

    zwb_settle_counter u_settle (
        .clock      (clock),
        .clear      (clear),
        .load       (settle_load),
        .load_value (settle_value),
        .dec        (settle_dec),
        .zero       (settle_zero)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg  <= S_IDLE;
            opcode_reg <= 5'd0;
            lo_reg     <= 32'd0;
            hi_reg     <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        opcode_reg <= opcode;
                        state_reg  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_zero) begin
                        state_reg <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    lo_reg <= z_in[31:0];
                    // Single-word ops leave HI holding the last wide result.
                    if (is_wide_op(opcode_reg)) begin
                        hi_reg <= z_in[63:32];
                    end
                    state_reg <= S_XFER_LO;
                end
                S_XFER_LO: begin
                    if (bus_gnt) begin
                        state_reg <= is_wide_op(opcode_reg) ? S_XFER_HI : S_DONE;
                    end
                end
                S_XFER_HI: begin
                    if (bus_gnt) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Request is a pure state decode; the grant only gates the actual drive.
    assign in_xfer   = (state_reg == S_XFER_LO) || (state_reg == S_XFER_HI);
    assign bus_req   = in_xfer;
    assign bus_drive = in_xfer && bus_gnt;
    assign bus_out   = !bus_drive                ? 32'd0  :
                       (state_reg == S_XFER_HI)  ? hi_reg : lo_reg;

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);
    assign lo   = lo_reg;
    assign hi   = hi_reg;

endmodule

// File: tb/tb_z_writeback.sv
// tb_z_writeback
// Directed scenarios followed by randomized operations. Each operation's
// expected cycle-by-cycle behaviour is derived from a transaction model:
// settle length from the opcode, word transfers from the grant pattern,
// and the LO/HI contents from the Z value.
module tb_z_writeback;

    localparam int MUL_W = 4;
    localparam int DIV_W = 8;

    logic        clock;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [63:0] z_in;
    logic        bus_gnt;
    logic        busy;
    logic        bus_req;
    logic [31:0] bus_out;
    logic        bus_drive;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0] lo_m;
    logic [31:0] hi_m;

    logic [4:0] op_list [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                5'b10000, 5'b10001, 5'b10010};
    logic [4:0] undef_list [3] = '{5'b11111, 5'b00000, 5'b01100};

    z_writeback #(.MUL_WAIT(MUL_W), .DIV_WAIT(DIV_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .z_in      (z_in),
        .bus_gnt   (bus_gnt),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .lo        (lo),
        .hi        (hi),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".bus_req"},   64'(bus_req),   64'd0);
        chk({tag, ".bus_drive"}, 64'(bus_drive), 64'd0);
        chk({tag, ".bus_out"},   64'(bus_out),   64'd0);
        chk({tag, ".done"},      64'(done),      64'd0);
        chk({tag, ".lo"},        64'(lo),        64'd0);
        chk({tag, ".hi"},        64'(hi),        64'd0);
    endtask

    // gmode: 0 grant always high, 1 random grant, 2 grant low for the first
    //        5 cycles of the LO transfer then high.
    // smode: 0 no extra starts, 1 random extra starts while busy,
    //        2 extra starts in the first LO transfer cycle and the DONE cycle.
    task automatic run_op(input logic [4:0] op, input logic [63:0] z,
                          input int gmode, input int smode);
        bit          gnt [64];
        int          word_c [2];
        int          settle, c0, need, nw, c, last_c, done_c;
        bit          wide, in_x, drv_e;
        logic [31:0] lo_new, hi_new, out_e;

        wide   = (op == 5'b10000) || (op == 5'b01111);
        settle = (op == 5'b10000) ? MUL_W : (op == 5'b01111) ? DIV_W : 1;
        c0     = settle + 2;          // first cycle in XFER_LO
        need   = wide ? 2 : 1;
        for (int i = 0; i < 64; i++) begin
            case (gmode)
                0:       gnt[i] = 1'b1;
                1:       gnt[i] = (i >= c0 + 20) ? 1'b1 : 1'($urandom_range(0, 1));
                default: gnt[i] = !((i >= c0) && (i < c0 + 5));
            endcase
        end
        word_c[0] = 0;
        word_c[1] = 0;
        nw = 0;
        c  = c0;
        while (nw < need) begin
            if (gnt[c]) begin
                word_c[nw] = c;
                nw++;
            end
            if (nw < need) c++;
        end
        last_c = c;
        done_c = c + 1;
        lo_new = z[31:0];
        hi_new = wide ? z[63:32] : hi_m;

        @(posedge clock);
        #1;
        for (int k = 0; k <= done_c; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            case (smode)
                1:       start = (k == 0) || ($urandom_range(0, 3) == 0);
                2:       start = (k == 0) || (k == c0) || (k == done_c);
                default: start = (k == 0);
            endcase
            opcode  = op;
            z_in    = z;
            bus_gnt = gnt[k];
            @(negedge clock);
            in_x  = (k >= c0) && (k <= last_c);
            drv_e = in_x && gnt[k];
            out_e = !drv_e ? 32'd0 : (k == word_c[0]) ? lo_new : hi_new;
            chk($sformatf("busy@c%0d", k),      64'(busy),      64'((k >= 1) && (k <= done_c)));
            chk($sformatf("bus_req@c%0d", k),   64'(bus_req),   64'(in_x));
            chk($sformatf("bus_drive@c%0d", k), 64'(bus_drive), 64'(drv_e));
            chk($sformatf("bus_out@c%0d", k),   64'(bus_out),   64'(out_e));
            chk($sformatf("done@c%0d", k),      64'(done),      64'(k == done_c));
            if (k == done_c) begin
                chk("lo_final", 64'(lo), 64'(lo_new));
                chk("hi_final", 64'(hi), 64'(hi_new));
            end
        end
        lo_m = lo_new;
        hi_m = hi_new;
        $display("txn op=%b z=%h lo=%h hi=%h done_cycle=%0d gmode=%0d smode=%0d",
                 op, z, lo, hi, done_c, gmode, smode);
    endtask

    initial begin
        logic [4:0]  op;
        logic [63:0] z;

        clear   = 1'b1;
        start   = 1'b0;
        opcode  = 5'd0;
        z_in    = 64'd0;
        bus_gnt = 1'b1;
        lo_m    = 32'd0;
        hi_m    = 32'd0;

        // Power-on reset
        #3 clear = 1'b0;
        #1 chk_all_zero("por");
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Add, grant tied high
        run_op(5'b00011, 64'h0000_0000_0000_0007, 0, 0);
        // Multiply -6, grant tied high
        run_op(5'b10000, 64'hFFFF_FFFF_FFFF_FFFA, 0, 0);
        // Division with a 5-cycle grant stall
        run_op(5'b01111, 64'h0000_0002_0000_0003, 2, 0);
        // Undefined opcode: ALU presents 0, HI must keep 2
        run_op(5'b11111, 64'h0, 0, 0);
        // Extra starts in XFER_LO and DONE are ignored
        run_op(5'b00100, 64'h1234_5678_9ABC_DEF0, 0, 2);

        // Reset during Division SETTLE takes effect without a clock edge
        @(posedge clock);
        #1;
        start   = 1'b1;
        opcode  = 5'b01111;
        z_in    = 64'hDEAD_BEEF_CAFE_F00D;
        bus_gnt = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #2 clear = 1'b0;
        #1 chk_all_zero("rst_async");
        @(posedge clock);
        #1 chk_all_zero("rst_held");
        @(negedge clock);
        clear = 1'b1;
        lo_m  = 32'd0;
        hi_m  = 32'd0;
        run_op(5'b00011, 64'h0000_0000_0000_0042, 0, 0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = undef_list[$urandom_range(0, 2)];
                z  = 64'd0;
            end else begin
                op = op_list[$urandom_range(0, 12)];
                z  = {$urandom, $urandom};
            end
            run_op(op, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("idle_after_all.busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
